// File: rtl/display_pkg.sv
// display_pkg: shared types, sizes and helpers for the display value sequencer.
package display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W = 4;
    localparam int unsigned MAX_VALUE = 9999;
    localparam int DABBLE_BITS = 14;
    localparam int BCD_W = NUM_DIGITS * DIGIT_W;
    localparam int SR_W = BCD_W + DABBLE_BITS;
    localparam int SHIFT_CNT_W = $clog2(DABBLE_BITS);
    localparam logic [SHIFT_CNT_W-1:0] SHIFT_LAST = SHIFT_CNT_W'(DABBLE_BITS - 1);

    // A digit is a leading zero only while every more significant digit is also zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [BCD_W-1:0] d);
        logic z;
        lz_mask = '0;
        z = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z = z && (d[i*DIGIT_W +: DIGIT_W] == '0);
            lz_mask[i] = z;
        end
    endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration, add 3 to every BCD nibble >= 5 then shift left.
module bcd_dabble_step
    import display_pkg::*;
(
    input  logic [SR_W-1:0] sr_i,
    output logic [SR_W-1:0] sr_o
);
    always_comb begin
        sr_o = sr_i;
        for (int i = 0; i < NUM_DIGITS; i++)
            sr_o[DABBLE_BITS + i*DIGIT_W +: DIGIT_W] = (sr_o[DABBLE_BITS + i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5)) ? sr_o[DABBLE_BITS + i*DIGIT_W +: DIGIT_W] + DIGIT_W'(3) : sr_o[DABBLE_BITS + i*DIGIT_W +: DIGIT_W];
        sr_o = sr_o << 1;
    end
endmodule

// File: rtl/display_value_sequencer.sv
// display_value_sequencer: binary-to-BCD front-end with atomic digit publish, leading-zero blanking and blink.
module display_value_sequencer
    import display_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2,
    parameter int VALUE_W  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VALUE_W-1:0] in_value,
    input  logic               blank_lz,
    input  logic               blink_en,
    output logic [DIGIT_W-1:0] bcd_thousands,
    output logic [DIGIT_W-1:0] bcd_hundreds,
    output logic [DIGIT_W-1:0] bcd_tens,
    output logic [DIGIT_W-1:0] bcd_ones,
    output logic [NUM_DIGITS-1:0] digit_blank,
    output logic               over,
    output logic               conv_done,
    output logic               busy
);
    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int CNT_W = HALF > 1 ? $clog2(HALF) : 1;

    state_t state_q, state_d;
    logic [SR_W-1:0] sr_q, sr_d, sr_step;
    logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] digits_q, digits_d;
    logic over_next_q, over_next_d, over_q, over_d, done_q, done_d;
    logic [CNT_W-1:0] blink_cnt_q;
    logic blink_phase_q, blink_wrap, in_over;
    logic [DABBLE_BITS-1:0] clamped;

    assign in_over = 32'(in_value) > MAX_VALUE;
    assign clamped = in_over ? DABBLE_BITS'(MAX_VALUE) : DABBLE_BITS'(in_value);

    bcd_dabble_step u_step (.sr_i(sr_q), .sr_o(sr_step));

    always_comb begin
        state_d = state_q;
        sr_d = sr_q;
        cnt_d = cnt_q;
        over_next_d = over_next_q;
        digits_d = digits_q;
        over_d = over_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: if (in_valid) begin
                sr_d = SR_W'(clamped);
                over_next_d = in_over;
                cnt_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d = sr_step;
                cnt_d = cnt_q + SHIFT_CNT_W'(1);
                state_d = (cnt_q == SHIFT_LAST) ? DONE : SHIFT;
            end
            DONE: begin
                digits_d = sr_q[SR_W-1 -: BCD_W];
                over_d = over_next_q;
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q <= '0;
            cnt_q <= '0;
            over_next_q <= 1'b0;
            digits_q <= '0;
            over_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q <= sr_d;
            cnt_q <= cnt_d;
            over_next_q <= over_next_d;
            digits_q <= digits_d;
            over_q <= over_d;
            done_q <= done_d;
        end
    end

    // Free-running so that enabling blink never shifts the phase.
    assign blink_wrap = blink_cnt_q == CNT_W'(HALF - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + CNT_W'(1);
            blink_phase_q <= blink_phase_q ^ blink_wrap;
        end
    end

    assign in_ready = state_q == IDLE;
    assign busy = !in_ready;
    assign conv_done = done_q;
    assign over = over_q;
    assign {bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones} = digits_q;
    assign digit_blank = (blink_en && blink_phase_q) ? '1 : (blank_lz ? lz_mask(digits_q) : '0);
endmodule

// File: doc/display_value_sequencer.md
# display_value_sequencer

Sequential front-end for the four-digit 7-segment display controller. It accepts a binary value over a valid/ready handshake and converts it to four BCD digits with an iterative shift-and-add-3 (double-dabble) engine. It publishes the digits atomically and produces a per-digit blank mask for leading-zero suppression and display blinking. It sits between value producers (counters, stopwatch logic) and the display multiplexer.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BLINK_HZ, 2, blink rate in Hz; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
- VALUE_W, 14, width of the input binary value
- One clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a value
- in_ready  out  1  block can accept; high only in IDLE
- in_value  in  VALUE_W  binary value to display
- blank_lz  in  1  enable leading-zero suppression
- blink_en  in  1  enable whole-display blinking
- bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones  out  4 each  published BCD digits
- digit_blank  out  4  blank mask, bit 3 = thousands … bit 0 = ones; 1 = digit off
- over  out  1  last accepted value exceeded 9999 and was clamped
- conv_done  out  1  one-cycle pulse when new digits are published
- busy  out  1  conversion in progress; equals !in_ready

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch min(in_value, 9999) into the low bits of a 30-bit shift register (16 BCD bits + 14 binary bits), with BCD bits cleared.
  - Set over_next = (in_value > 9999), clear shift count, go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift the whole register left by 1. After the 14th shift, go to DONE.
- DONE:
  - Register the four BCD nibbles into the bcd_* outputs and over_next into over.
  - Pulse conv_done for exactly one cycle.
  - Go to IDLE.
- Published digits change only at the DONE edge. They never show intermediate shift state.
- in_valid while busy is ignored. The producer must hold in_valid and in_value until in_ready is high.
- Leading-zero mask, when blank_lz = 1:
  - thousands is blank if thousands == 0.
  - hundreds is blank if thousands and hundreds are both 0.
  - tens is blank if thousands, hundreds and tens are all 0.
  - ones is never blanked by this rule.
  - When blank_lz = 0, the leading-zero mask is 0000.
- Blink:
  - A free-running counter toggles blink_phase every CLK_HZ/(2*BLINK_HZ) cycles.
  - When blink_en && blink_phase, digit_blank = 1111.
  - Otherwise digit_blank = the leading-zero mask.
- digit_blank is combinational from registered digits, blink_phase, blank_lz and blink_en.
- Values 0–9999 convert exactly. Values 10000–16383 display 9999 with over = 1.

## Timing
- Handshake edge E0:
  - in_ready and busy flip at E0.
  - Shifts occur at E1..E14; state is DONE after E14.
  - At E15 the outputs update, conv_done is high from E15 to E16, and in_ready returns high.
- Throughput: one conversion per 16 cycles (accept to next accept with in_valid held).
- Reset values:
  - State IDLE, in_ready = 1, busy = 0.
  - All bcd_* = 0, over = 0, conv_done = 0.
  - Blink counter = 0, blink_phase = 0.
  - digit_blank = 1110 if blank_lz else 0000.
- Reset asserted mid-SHIFT or mid-DONE aborts the conversion: no conv_done pulse, digits reset to 0.
- blink_en rising mid-period has no effect on counter phase.

## Structure
- Package display_pkg holds:
  - the state enum (IDLE/SHIFT/DONE)
  - NUM_DIGITS = 4, DIGIT_W = 4, MAX_VALUE = 9999
  - DABBLE_BITS = 14
- One sub-module is natural: bcd_dabble_step, a combinational add-3-then-shift of the 30-bit register, instantiated once.
- The blink timer stays inline.

## Test plan
- Reset with blank_lz = 1 → bcd_* = 0, over = 0, in_ready = 1, digit_blank = 1110; with blank_lz = 0 → digit_blank = 0000.
- Accept 1234 at E0 → busy for 15 cycles, conv_done one cycle after E15, digits 1/2/3/4, digit_blank = 0000.
- Accept 16383 → digits 9/9/9/9, over = 1; then accept 0 → digits 0/0/0/0, over = 0, digit_blank = 1110 (blank_lz = 1).
- blank_lz = 1:
  - 42 → digit_blank = 1100
  - 1005 → 0000
  - 7 → 1110
- Hold in_valid with 7 while busy on 5678 → 7 is accepted only at the first in_ready cycle after the 5678 conv_done. Separately, assert rst_n low at E5 of a conversion of 999 → no conv_done, digits 0.
- CLK_HZ = 8, BLINK_HZ = 1, blink_en = 1 on value 88 → digit_blank alternates 0000 for 4 cycles and 1111 for 4 cycles (blank_lz = 0); blink_en = 0 → constant 0000.
